// File: rtl/joy_pkg.sv
// Shared definitions for the Amiga joystick conditioning path.
package joy_pkg;

  localparam int unsigned JOY_FIRE2 = 5;
  localparam int unsigned JOY_FIRE  = 4;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_RIGHT = 0;

  localparam int unsigned JOY_W = 8;
  localparam int unsigned SW_W  = 6;

  localparam logic [JOY_W-1:0] JOY_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    AF_IDLE = 2'd0,
    AF_ON   = 2'd1,
    AF_OFF  = 2'd2
  } af_state_e;

endpackage

// File: rtl/joy_debounce_bit.sv
// Single-switch debouncer: the output flips only after the sample has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
module joy_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic d
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          d_q, d_d;

  // Any cycle where the sample agrees with the output restarts the count.
  always_comb begin
    cnt_d = '0;
    d_d   = d_q;
    if (s != d_q) begin
      if (cnt_q == CNT_MAX) begin
        d_d = s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      d_q   <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      d_q   <= d_d;
    end
  end

  assign d = d_q;

endmodule

// File: rtl/joy_conditioner.sv
// Debounces both raw joystick words, adds per-port autofire on the primary fire
// button and pulses chg whenever a conditioned word changes.
module joy_conditioner
  import joy_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned AUTOFIRE_HALF   = 700000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_ready,
  input  logic [JOY_W-1:0] joya_in,
  input  logic [JOY_W-1:0] joyb_in,
  input  logic [1:0]       af_en,
  output logic [JOY_W-1:0] joya_out,
  output logic [JOY_W-1:0] joyb_out,
  output logic             chg
);

  localparam int unsigned HW = $clog2(AUTOFIRE_HALF);
  localparam logic [HW-1:0] HC_MAX = HW'(AUTOFIRE_HALF - 1);

  logic [1:0][SW_W-1:0]  s_q;
  logic [1:0][SW_W-1:0]  deb;
  logic [1:0]            af_fire;
  logic [1:0][JOY_W-1:0] out_d, out_q;
  logic                  chg_d, chg_q;

  // Bits [7:6] are constant on the output, so the raw copies are dropped.
  logic unused_hi;
  assign unused_hi = ^{joya_in[7:6], joyb_in[7:6]};

  for (genvar p = 0; p < 2; p++) begin : g_port
    for (genvar b = 0; b < int'(SW_W); b++) begin : g_bit
      joy_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk (clk),
        .rst (rst),
        .s   (s_q[p][b]),
        .d   (deb[p][b])
      );
    end

    af_state_e     st_q, st_d;
    logic [HW-1:0] hc_q, hc_d;
    logic          d4;
    logic          fire_c;

    assign d4 = deb[p][JOY_FIRE];

    // Autofire FSM; a release or disable drops straight back to the debounced level.
    always_comb begin
      st_d   = st_q;
      hc_d   = hc_q;
      fire_c = d4;
      unique case (st_q)
        AF_IDLE: begin
          if (af_en[p] && !d4) begin
            st_d = AF_ON;
            // The idle cycle already drives the first low of the phase.
            hc_d = HW'(1);
          end
        end
        AF_ON: begin
          fire_c = 1'b0;
          if (hc_q == HC_MAX) begin
            st_d = AF_OFF;
            hc_d = '0;
          end else begin
            hc_d = hc_q + HW'(1);
          end
        end
        AF_OFF: begin
          fire_c = 1'b1;
          if (hc_q == HC_MAX) begin
            st_d = AF_ON;
            hc_d = '0;
          end else begin
            hc_d = hc_q + HW'(1);
          end
        end
        default: begin
          st_d = AF_IDLE;
          hc_d = '0;
        end
      endcase
      if ((st_q != AF_IDLE) && (d4 || !af_en[p])) begin
        st_d   = AF_IDLE;
        hc_d   = '0;
        fire_c = d4;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q <= AF_IDLE;
        hc_q <= '0;
      end else begin
        st_q <= st_d;
        hc_q <= hc_d;
      end
    end

    assign af_fire[p] = fire_c;
  end

  always_comb begin
    out_d = '0;
    for (int p = 0; p < 2; p++) begin
      out_d[p] = {2'b11, deb[p][JOY_FIRE2], af_fire[p], deb[p][JOY_UP:JOY_RIGHT]};
    end
    chg_d = (out_d != out_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= {2{JOY_IDLE[SW_W-1:0]}};
      out_q <= {2{JOY_IDLE}};
      chg_q <= 1'b0;
    end else begin
      s_q[0] <= src_ready ? joya_in[SW_W-1:0] : JOY_IDLE[SW_W-1:0];
      s_q[1] <= src_ready ? joyb_in[SW_W-1:0] : JOY_IDLE[SW_W-1:0];
      out_q  <= out_d;
      chg_q  <= chg_d;
    end
  end

  assign joya_out = out_q[0];
  assign joyb_out = out_q[1];
  assign chg      = chg_q;

endmodule

// File: tb/tb_joy_conditioner.sv
// Directed bench for joy_conditioner with a cycle-level reference model feeding a scoreboard.
module tb_joy_conditioner;

  localparam int DB = 4;
  localparam int AH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       src_ready = 1'b1;
  logic [7:0] joya_in = 8'hFF;
  logic [7:0] joyb_in = 8'hFF;
  logic [1:0] af_en = 2'b00;
  logic [7:0] joya_out, joyb_out;
  logic       chg;

  joy_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .AUTOFIRE_HALF  (AH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_ready(src_ready),
    .joya_in  (joya_in),
    .joyb_in  (joyb_in),
    .af_en    (af_en),
    .joya_out (joya_out),
    .joyb_out (joyb_out),
    .chg      (chg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference state, held at its reset values.
  logic [7:0] m_s   [2] = '{8'hFF, 8'hFF};
  logic [5:0] m_d   [2] = '{6'h3F, 6'h3F};
  int         m_cnt [2][6];
  int         m_aft [2] = '{0, 0};
  logic [7:0] m_out [2] = '{8'hFF, 8'hFF};
  logic       m_chg = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    logic [7:0] no [2];
    logic [7:0] in_w [2];
    logic       d4, act, f;
    exp_t       e;
    in_w[0] = joya_in;
    in_w[1] = joyb_in;
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        m_s[p] = 8'hFF; m_d[p] = 6'h3F; m_aft[p] = 0; m_out[p] = 8'hFF;
        for (int b = 0; b < 6; b++) m_cnt[p][b] = 0;
      end
      m_chg = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        d4  = m_d[p][4];
        act = af_en[p] && !d4;
        if (act) begin
          f = ((m_aft[p] / AH) % 2) != 0;
          m_aft[p]++;
        end else begin
          f = d4;
          m_aft[p] = 0;
        end
        no[p] = {2'b11, m_d[p][5], f, m_d[p][3:0]};
      end
      m_chg = (no[0] != m_out[0]) || (no[1] != m_out[1]);
      m_out[0] = no[0];
      m_out[1] = no[1];
      for (int p = 0; p < 2; p++) begin
        for (int b = 0; b < 6; b++) begin
          if (m_s[p][b] == m_d[p][b]) m_cnt[p][b] = 0;
          else if (m_cnt[p][b] < DB - 1) m_cnt[p][b]++;
          else begin m_d[p][b] = m_s[p][b]; m_cnt[p][b] = 0; end
        end
        m_s[p] = src_ready ? in_w[p] : 8'hFF;
      end
    end
    e.a = m_out[0];
    e.b = m_out[1];
    e.c = m_chg;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_joya", 32'(joya_out), 32'(e.a));
    chk("sb_joyb", 32'(joyb_out), 32'(e.b));
    chk("sb_chg",  32'(chg),      32'(e.c));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Watch n cycles: first cycle each output differs from its start value, and chg count.
  task automatic run_watch(input int n, output int lat_a, output int lat_b, output int nchg);
    logic [7:0] a0, b0;
    a0 = joya_out;
    b0 = joyb_out;
    lat_a = 0; lat_b = 0; nchg = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (chg === 1'b1) nchg++;
      if (lat_a == 0 && joya_out !== a0) lat_a = i;
      if (lat_b == 0 && joyb_out !== b0) lat_b = i;
    end
  endtask

  task automatic wait_fire_low(input int n, output int lat);
    lat = 0;
    for (int i = 1; i <= n && lat == 0; i++) begin
      tick();
      if (joya_out[4] === 1'b0) lat = i;
    end
  endtask

  int la, lb, nc, lf;

  initial begin
    // Reset held with every switch pressed on port A.
    rst = 1'b1;
    joya_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_joya", 32'(joya_out), 32'h0FF);
      chk("rst_joyb", 32'(joyb_out), 32'h0FF);
      chk("rst_chg",  32'(chg),      32'h0);
    end
    rst = 1'b0;
    run_watch(10, la, lb, nc);
    chk("rst_rel_lat", 32'(la), 32'd6);
    chk("rst_rel_val", 32'(joya_out), 32'h0C0);
    chk("rst_rel_chg", 32'(nc), 32'd1);

    joya_in = 8'hFF;
    ticks(10);
    chk("idle_joya", 32'(joya_out), 32'h0FF);

    // Bounce on UP: 2-cycle runs never survive the debounce.
    for (int i = 0; i < 20; i++) begin
      joya_in = (((i / 2) % 2) == 0) ? 8'hF7 : 8'hFF;
      tick();
      chk("bounce_hold", 32'(joya_out), 32'h0FF);
    end
    joya_in = 8'hF7;
    run_watch(10, la, lb, nc);
    chk("bounce_lat", 32'(la), 32'd6);
    chk("bounce_val", 32'(joya_out), 32'h0F7);
    chk("bounce_chg", 32'(nc), 32'd1);

    joya_in = 8'hFF;
    ticks(10);

    // Autofire on port A.
    af_en = 2'b01;
    joya_in = 8'hEF;
    wait_fire_low(20, lf);
    chk("af_lat", 32'(lf), 32'd6);
    chk("af_chg0", 32'(chg), 32'h1);
    for (int j = 1; j < 12; j++) begin
      tick();
      chk("af_fire", 32'(joya_out[4]), 32'((j / 3) % 2));
      chk("af_chg",  32'(chg), 32'((j % 3) == 0));
    end
    joya_in = 8'hFF;
    ticks(12);
    chk("af_release", 32'(joya_out), 32'h0FF);
    ticks(6);

    // Autofire disabled in the low phase.
    joya_in = 8'hEF;
    wait_fire_low(20, lf);
    chk("afd_lat", 32'(lf), 32'd6);
    tick();
    af_en = 2'b00;
    tick();
    chk("afd_val", 32'(joya_out), 32'h0EF);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("afd_steady", 32'(joya_out), 32'h0EF);
      chk("afd_nochg",  32'(chg), 32'h0);
    end
    joya_in = 8'hFF;
    ticks(10);
    chk("afd_release", 32'(joya_out), 32'h0FF);

    // Both ports together, then src_ready drop.
    joya_in = 8'hFE;
    joyb_in = 8'hFD;
    run_watch(10, la, lb, nc);
    chk("sim_lat_a", 32'(la), 32'd6);
    chk("sim_lat_b", 32'(lb), 32'd6);
    chk("sim_chg",   32'(nc), 32'd1);
    chk("sim_val_a", 32'(joya_out), 32'h0FE);
    chk("sim_val_b", 32'(joyb_out), 32'h0FD);
    src_ready = 1'b0;
    run_watch(10, la, lb, nc);
    chk("srdy_lat_a", 32'(la), 32'd6);
    chk("srdy_lat_b", 32'(lb), 32'd6);
    chk("srdy_chg",   32'(nc), 32'd1);
    chk("srdy_val_a", 32'(joya_out), 32'h0FF);
    chk("srdy_val_b", 32'(joyb_out), 32'h0FF);
    src_ready = 1'b1;
    joya_in = 8'hFF;
    joyb_in = 8'hFF;
    ticks(6);

    // Reset asserted in the high phase of autofire.
    af_en = 2'b01;
    joya_in = 8'hEF;
    wait_fire_low(20, lf);
    chk("afr_lat", 32'(lf), 32'd6);
    ticks(3);
    chk("afr_off", 32'(joya_out[4]), 32'h1);
    rst = 1'b1;
    tick();
    chk("afr_rst_joya", 32'(joya_out), 32'h0FF);
    chk("afr_rst_chg",  32'(chg), 32'h0);
    tick();
    rst = 1'b0;
    wait_fire_low(20, lf);
    chk("afr_relat", 32'(lf), 32'd6);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("afr_phase", 32'(joya_out[4]), 32'((j / 3) % 2));
    end
    joya_in = 8'hFF;
    af_en = 2'b00;
    ticks(10);
    chk("final_joya", 32'(joya_out), 32'h0FF);
    chk("final_joyb", 32'(joyb_out), 32'h0FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
